// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/load-store arbiter for one sync memory port; define ARB_ROUND_ROBIN_EN for round-robin ties
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic              IfGnt,
    output logic              IfValid,
    output logic [DATA_W-1:0] IfRdata,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic              DGnt,
    output logic              DValid,
    output logic [DATA_W-1:0] DRdata,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    output logic              Busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
    state_t state;
    logic [2:0] cnt;
    logic win_d, we, pick_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_if;
    always_comb pick_d = DReq && (!IfReq || last_if);
    always_ff @(posedge Clock)
        if (Reset) last_if <= 1'b1;
        else if (state == IDLE && (IfReq || DReq)) last_if <= !pick_d;
`else
    always_comb pick_d = DReq;
`endif
    assign Busy = state != IDLE;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= 3'd0;
            win_d <= 1'b0;
            we <= 1'b0;
            IfGnt <= 1'b0;
            IfValid <= 1'b0;
            IfRdata <= '0;
            DGnt <= 1'b0;
            DValid <= 1'b0;
            DRdata <= '0;
            MemEn <= 1'b0;
            MemWe <= 1'b0;
            MemAddr <= '0;
            MemWdata <= '0;
        end else begin
            IfGnt <= 1'b0;
            DGnt <= 1'b0;
            IfValid <= 1'b0;
            DValid <= 1'b0;
            MemEn <= 1'b0;
            MemWe <= 1'b0;
            case (state)
                IDLE: if (IfReq || DReq) begin
                    state <= ACCESS;
                    win_d <= pick_d;
                    we <= pick_d && DWe;
                    MemEn <= 1'b1;
                    MemWe <= pick_d && DWe;
                    MemAddr <= pick_d ? DAddr : IfAddr;
                    MemWdata <= pick_d ? DWdata : MemWdata;
                    IfGnt <= !pick_d;
                    DGnt <= pick_d;
                end
                ACCESS: begin
                    state <= WAIT;
                    cnt <= LAT_M1;
                end
                WAIT: if (cnt == 3'd0) begin
                    state <= RESP;
                    IfValid <= !win_d;
                    DValid <= win_d;
                    if (!we && win_d) DRdata <= MemRdata;
                    if (!we && !win_d) IfRdata <= MemRdata;
                end else cnt <= cnt - 3'd1;
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench driving LATENCY=1,2,4 instances from shared requester inputs
module tb_mem_port_arbiter;
    logic clk, rst, if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [2:0] if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [15:0] if_rdata [3];
    logic [15:0] d_rdata [3];
    logic [15:0] mem_addr [3];
    logic [15:0] mem_wdata [3];
    logic [15:0] mem_rdata [3];
    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g == 0 ? 1 : g == 1 ? 2 : 4;
        logic [15:0] mem [256];
        logic [15:0] pipe [4];
        mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(L)) u_dut (
            .Clock(clk), .Reset(rst),
            .IfReq(if_req), .IfAddr(if_addr), .IfGnt(if_gnt[g]), .IfValid(if_valid[g]), .IfRdata(if_rdata[g]),
            .DReq(d_req), .DWe(d_we), .DAddr(d_addr), .DWdata(d_wdata),
            .DGnt(d_gnt[g]), .DValid(d_valid[g]), .DRdata(d_rdata[g]),
            .MemEn(mem_en[g]), .MemWe(mem_we[g]), .MemAddr(mem_addr[g]), .MemWdata(mem_wdata[g]),
            .MemRdata(mem_rdata[g]), .Busy(busy[g])
        );
        always @(posedge clk) begin
            if (rst) mem[8'h10] <= 16'hA5A5;
            else if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
            pipe[0] <= mem_en[g] ? mem[mem_addr[g][7:0]] : 16'hDEAD;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 3'b000 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL wait_idle busy=%b required 000", busy);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        if_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy} !== 21'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%h required 0", {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy});
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({if_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]} !== 64'b0) begin
                errors++;
                $display("FAIL reset_data[%0d] got=%h required 0", g, {if_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_busy got=%b required 000", busy);
        end
    endtask

    task automatic test_fetch();
        if_req = 1'b1;
        if_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({mem_en[0], if_gnt[0], mem_we[0], d_gnt[0]} !== 4'b1100) begin
            errors++;
            $display("FAIL fetch_access en/gnt/we/dgnt got=%b required 1100", {mem_en[0], if_gnt[0], mem_we[0], d_gnt[0]});
        end
        checks++;
        if (mem_addr[0] !== 16'h0010) begin
            errors++;
            $display("FAIL fetch_addr got=%h required 0010", mem_addr[0]);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en[0], if_gnt[0], if_valid[0]} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_wait en/gnt/valid got=%b required 000", {mem_en[0], if_gnt[0], if_valid[0]});
        end
        @(negedge clk);
        checks++;
        if (if_valid[0] !== 1'b1 || if_rdata[0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL fetch_resp valid=%b data=%h required 1/a5a5", if_valid[0], if_rdata[0]);
        end
        @(negedge clk);
        checks++;
        if (if_valid[0] !== 1'b0 || if_rdata[0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL fetch_hold valid=%b data=%h required 0/a5a5", if_valid[0], if_rdata[0]);
        end
        wait_idle();
    endtask

    task automatic test_store_load();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 16'h0100;
        d_wdata = 16'h1234;
        @(negedge clk);
        checks++;
        if ({mem_en[0], mem_we[0], d_gnt[0], if_gnt[0]} !== 4'b1110 || mem_wdata[0] !== 16'h1234 || mem_addr[0] !== 16'h0100) begin
            errors++;
            $display("FAIL store_access flags=%b wdata=%h addr=%h required 1110/1234/0100",
                     {mem_en[0], mem_we[0], d_gnt[0], if_gnt[0]}, mem_wdata[0], mem_addr[0]);
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_valid[0] !== 1'b1 || d_rdata[0] !== 16'h0000 || if_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL store_resp dvalid=%b drdata=%h ivalid=%b required 1/0000/0", d_valid[0], d_rdata[0], if_valid[0]);
        end
        wait_idle();
        d_req = 1'b1;
        d_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en[0], mem_we[0], d_gnt[0]} !== 3'b101) begin
            errors++;
            $display("FAIL load_access en/we/gnt got=%b required 101", {mem_en[0], mem_we[0], d_gnt[0]});
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d_valid[0] !== 1'b1 || d_rdata[0] !== 16'h1234) begin
            errors++;
            $display("FAIL load_resp valid=%b data=%h required 1/1234", d_valid[0], d_rdata[0]);
        end
        wait_idle();
    endtask

    task automatic test_arbitration();
        logic [3:0] order = '0;
        logic [3:0] expected;
        int at [4];
        int cnt = 0;
        int n = 0;
        logic both = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        expected = 4'b0101;
`else
        expected = 4'b1111;
`endif
        do_reset();
        if_req = 1'b1;
        d_req = 1'b1;
        d_we = 1'b0;
        if_addr = 16'h0010;
        d_addr = 16'h0100;
        while (cnt < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (if_gnt[1] && d_gnt[1]) both = 1'b1;
            if (if_gnt[1] || d_gnt[1]) begin
                order[cnt] = d_gnt[1];
                at[cnt] = n;
                cnt++;
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        checks++;
        if (cnt != 4 || order !== expected) begin
            errors++;
            $display("FAIL arb_order grants=%0d order(bit0 first,1=D)=%b required 4/%b", cnt, order, expected);
        end
        checks++;
        if (cnt == 4 && (at[1] - at[0] != 5 || at[2] - at[1] != 5 || at[3] - at[2] != 5)) begin
            errors++;
            $display("FAIL arb_spacing gaps=%0d,%0d,%0d required 5,5,5", at[1] - at[0], at[2] - at[1], at[3] - at[2]);
        end
        checks++;
        if (both) begin
            errors++;
            $display("FAIL arb_dual_grant got=1 required 0");
        end
        wait_idle();
    endtask

    task automatic test_latency_sweep();
        for (int rep = 0; rep < 2; rep++) begin
            int vpos = 0;
            if (rep == 0) begin
                if_req = 1'b1;
                if_addr = 16'h0010;
            end else begin
                d_req = 1'b1;
                d_we = 1'b0;
                d_addr = 16'h0100;
            end
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    if_req = 1'b0;
                    d_req = 1'b0;
                end
                checks++;
                if (busy[2] !== 1'(k <= 6)) begin
                    errors++;
                    $display("FAIL sweep_busy rep=%0d cycle=T+%0d got=%b required %b", rep, k, busy[2], k <= 6);
                end
                if ((if_valid[2] || d_valid[2]) && vpos == 0) vpos = k;
            end
            checks++;
            if (vpos != 6) begin
                errors++;
                $display("FAIL sweep_valid rep=%0d valid at T+%0d required T+6", rep, vpos);
            end
            wait_idle();
        end
    endtask

    task automatic test_reset_mid();
        logic saw = 1'b0;
        int vpos = 0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 16'h0100;
        @(negedge clk);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy} !== 21'b0) begin
            errors++;
            $display("FAIL midreset_strobes got=%h required 0", {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy});
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({if_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]} !== 64'b0) begin
                errors++;
                $display("FAIL midreset_data[%0d] got=%h required 0", g, {if_rdata[g], d_rdata[g], mem_addr[g], mem_wdata[g]});
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (d_valid[2]) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL midreset_dvalid got=1 required 0");
        end
        wait_idle();
        if_req = 1'b1;
        if_addr = 16'h0010;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) if_req = 1'b0;
            if (if_valid[2] && vpos == 0) vpos = k;
        end
        checks++;
        if (vpos != 6 || if_rdata[2] !== 16'hA5A5) begin
            errors++;
            $display("FAIL midreset_refetch valid at T+%0d data=%h required T+6/a5a5", vpos, if_rdata[2]);
        end
        wait_idle();
    endtask

    task automatic test_drop();
        int n = 0;
        logic saw_if = 1'b0;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 16'h0100;
        @(negedge clk);
        d_req = 1'b0;
        if_req = 1'b1;
        if_addr = 16'h0010;
        while (busy[2] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if_req = 1'b0;
        d_req = 1'b1;
        @(negedge clk);
        d_req = 1'b0;
        checks++;
        if ({d_gnt[2], if_gnt[2]} !== 2'b10) begin
            errors++;
            $display("FAIL drop_grant dgnt/ignt got=%b required 10", {d_gnt[2], if_gnt[2]});
        end
        n = 0;
        while (busy[2] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
            if (if_gnt[2]) saw_if = 1'b1;
        end
        checks++;
        if (saw_if || d_rdata[2] !== 16'h1234) begin
            errors++;
            $display("FAIL drop_complete ignt_seen=%b drdata=%h required 0/1234", saw_if, d_rdata[2]);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_arbitration();
        test_latency_sweep();
        test_reset_mid();
        test_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the CPU's single-port synchronous memory between the instruction-fetch unit and the load/store unit. It accepts one request at a time and drives the memory enable, write-enable, address and write-data for exactly one cycle. It then waits the memory read latency and returns read data, or a write acknowledge, to the granted requester. It sits between the CPU control/datapath and the memory block, inside the CPU top clocked by `Clock`.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `LATENCY`, 1: memory read latency in cycles, counted from the cycle `MemEn`=1 to the cycle `MemRdata` is valid. Legal range 1..4.

- `Clock`  in  1: sole clock; all logic updates on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `IfReq`  in  1: fetch request, level.
- `IfAddr`  in  ADDR_W: fetch address.
- `IfGnt`  out  1: one-cycle pulse; the fetch request has been issued to memory.
- `IfValid`  out  1: one-cycle pulse; `IfRdata` is valid.
- `IfRdata`  out  DATA_W: fetch data, held until the next fetch completes.
- `DReq`  in  1: load/store request, level.
- `DWe`  in  1: 1 = store, 0 = load.
- `DAddr`  in  ADDR_W: load/store address.
- `DWdata`  in  DATA_W: store data.
- `DGnt`  out  1: one-cycle pulse; the load/store request has been issued.
- `DValid`  out  1: one-cycle pulse; load data is valid or the store is done.
- `DRdata`  out  DATA_W: load data, held until the next load completes; not written by stores.
- `MemEn`  out  1: memory access strobe.
- `MemWe`  out  1: memory write enable, qualified by `MemEn`.
- `MemAddr`  out  ADDR_W: memory address.
- `MemWdata`  out  DATA_W: memory write data.
- `MemRdata`  in  DATA_W: memory read data.
- `Busy`  out  1: 1 whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: samples `IfReq`/`DReq`. Goes to ACCESS if either is 1, otherwise stays in IDLE.
  - ACCESS: lasts exactly 1 cycle, then goes to WAIT.
  - WAIT: lasts exactly LATENCY cycles, then goes to RESP.
  - RESP: lasts 1 cycle, then goes to IDLE.
- Arbitration happens at the IDLE edge where a request is seen:
  - Only one request present: that requester wins.
  - Both present: the winner follows the priority rule (see Configuration).
  - The winner ID, write flag, address and write data are latched into registers.
- ACCESS:
  - Drives `MemEn`=1, `MemWe`=latched write flag (always 0 for fetch), and `MemAddr`/`MemWdata` from the latched values.
  - Pulses the winner's `xGnt`.
  - Outside ACCESS, `MemEn`=`MemWe`=0. `MemAddr`/`MemWdata` hold their last value.
- WAIT:
  - A 3-bit down-counter is loaded with LATENCY-1 on entry and decremented each cycle.
  - On the final WAIT cycle (counter = 0), `MemRdata` is registered into the winner's data register, for reads only.
- RESP: pulses the winner's `xValid`.
- Requesters must hold `xReq` and the address/data stable until `xGnt`. Inputs are ignored from the latch edge onward.
- A requester may drop `xReq` before it is granted. A dropped request is simply not arbitrated.
- Each transaction occupies LATENCY+3 cycles from the IDLE sample cycle to the RESP cycle inclusive. A request held through RESP is sampled in the following IDLE cycle.

## Timing
- Reset values:
  - Outputs: all 0, including `IfRdata`, `DRdata`, `MemAddr` and `MemWdata`.
  - State: IDLE. Counter: 0.
  - Round-robin pointer: "fetch last".
- Sample cycle T (IDLE, request high):
  - T+1: ACCESS, with `MemEn`=1 and `xGnt`=1.
  - T+1+LATENCY: `MemRdata` is captured.
  - T+2+LATENCY: `xValid`=1, with the new `xRdata` visible in that same cycle.
- `xGnt` and `xValid` are each exactly one cycle wide. They are never asserted for both requesters in the same cycle.
- `Reset` mid-transaction: the next edge forces IDLE and all outputs to 0. The in-flight access is dropped with no `xValid` pulse. Any memory write already strobed stands.
- `Reset` has priority over every other input.

## Configuration
- Macro: `ARB_ROUND_ROBIN_EN`.
- Defined: when both requests are present, the requester not granted last wins. The pointer updates on every grant. Because it resets to "fetch last", the data port wins the first tie.
- Undefined: fixed priority; the data port always wins ties, so fetch can starve under continuous `DReq`. The pointer logic is not built.

## Test plan
- Single fetch, LATENCY=1, `IfAddr`=16'h0010, memory word 16'hA5A5:
  - `MemEn`/`IfGnt` in cycle T+1.
  - `IfValid`=1 with `IfRdata`=16'hA5A5 in cycle T+3.
- Store then load, `DAddr`=16'h0100, `DWdata`=16'h1234:
  - Store: `MemWe`=1 in ACCESS; `DValid` pulses; `DRdata` stays 0.
  - Load to the same address: returns 16'h1234.
- Simultaneous `IfReq`/`DReq` held high for 4 transactions, LATENCY=2:
  - With the macro: grant order D, I, D, I.
  - Without the macro: grant order D, D, D, D, with `IfGnt` never asserted.
- LATENCY=4 sweep: measure each transaction at exactly 7 cycles from IDLE sample to `xValid`; check `Busy` is high for cycles T+1..T+6.
- Assert `Reset` during WAIT of a load: the next cycle shows IDLE and all outputs 0; no `DValid` pulse appears; a following fetch completes normally.
- Drop `IfReq` in the same IDLE cycle that `DReq` rises: only the data transaction is issued and `IfGnt` stays 0.
